// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Op-code encoding and FSM state encoding used by the top level and the bench.
package mul_div_unit_pkg;

  // Operation encoding on the op port; 110/111 are MADD/MSUB when MDU_MADD_EN is defined
  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101,
    MDU_MADD  = 3'b110,
    MDU_MSUB  = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, opA, opB, cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, opA, opB, cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mul_div_unit_iter_core.sv
// Radix-2 iterative datapath: unsigned shift-add multiply and restoring divide.
// Operates on magnitudes only; sign handling lives in the top level.
// Multiply: {o_hi_part,o_lo_part} = product. Divide: o_lo_part = quotient, o_hi_part = remainder.
module mul_div_unit_iter_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_mag_a,
  input  logic [WIDTH-1:0] i_mag_b,
  output logic             o_step_done,
  output logic [WIDTH-1:0] o_hi_part,
  output logic [WIDTH-1:0] o_lo_part
);

  logic [WIDTH-1:0] r_acc;     // partial product high half / running remainder
  logic [WIDTH-1:0] r_lsr;     // multiplier bits / dividend bits becoming quotient
  logic [WIDTH-1:0] r_b;       // multiplicand / divisor
  logic             r_is_div;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_sub;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_lsr_next;

  // One radix-2 step of either algorithm
  always_comb begin
    w_sum   = {1'b0, r_acc} + {1'b0, r_b};
    w_add   = r_lsr[0] ? w_sum : {1'b0, r_acc};
    w_shift = {r_acc, r_lsr[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    // Remainder after a successful subtract is below the divisor, so WIDTH bits suffice
    w_sub   = w_shift[WIDTH-1:0] - r_b;
    if (r_is_div) begin
      w_acc_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
      w_lsr_next = {r_lsr[WIDTH-2:0], w_ge};
    end else begin
      w_acc_next = w_add[WIDTH:1];
      w_lsr_next = {w_add[0], r_lsr[WIDTH-1:1]};
    end
  end

  // Operand load and per-cycle iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_lsr    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_lsr    <= i_is_div ? i_mag_a : i_mag_b;
      r_b      <= i_is_div ? i_mag_b : i_mag_a;
      r_is_div <= i_is_div;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_acc <= w_acc_next;
      r_lsr <= w_lsr_next;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // High during the cycle that performs the final step
  assign o_step_done = (r_cnt == CNT_W'(WIDTH - 1));
  assign o_hi_part   = r_acc;
  assign o_lo_part   = r_lsr;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Latency: accepted at edge E0, HI/LO and done update at edge E(WIDTH+1).
// Optional MADD/MSUB accumulate ops are enabled with the macro MDU_MADD_EN.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           rst_n,
  mul_div_unit_if.slave bus
);

  mdu_state_e       r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_is_div;
  logic             r_neg_res;   // product / quotient must be negated
  logic             r_neg_rem;   // remainder takes the dividend's sign
  logic             r_div_zero;
`ifdef MDU_MADD_EN
  logic             r_madd;
  logic             r_msub;
`endif

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic             w_step_done;
  logic [WIDTH-1:0] w_core_hi;
  logic [WIDTH-1:0] w_core_lo;
  logic [2*WIDTH-1:0] w_prod_mag;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  // Decode op class and form operand magnitudes for the unsigned core
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_signed = 1'b0;
    unique case (bus.op)
      MDU_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
      MDU_MULTU: begin w_is_mul = 1'b1; end
      MDU_DIV:   begin w_is_div = 1'b1; w_signed = 1'b1; end
      MDU_DIVU:  begin w_is_div = 1'b1; end
`ifdef MDU_MADD_EN
      MDU_MADD, MDU_MSUB: begin w_is_mul = 1'b1; w_signed = 1'b1; end
`endif
      default: ;
    endcase
    w_a_neg  = w_signed & bus.opA[WIDTH-1];
    w_b_neg  = w_signed & bus.opB[WIDTH-1];
    w_mag_a  = w_a_neg ? -bus.opA : bus.opA;
    w_mag_b  = w_b_neg ? -bus.opB : bus.opB;
    // cancel wins over a same-cycle start
    w_accept = (r_state == StIdle) && bus.start && !bus.cancel;
    w_load   = w_accept && (w_is_mul || w_is_div);
    w_step   = (r_state == StCalc) && !bus.cancel;
  end

  mul_div_unit_iter_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_step      (w_step),
    .i_is_div    (w_is_div),
    .i_mag_a     (w_mag_a),
    .i_mag_b     (w_mag_b),
    .o_step_done (w_step_done),
    .o_hi_part   (w_core_hi),
    .o_lo_part   (w_core_lo)
  );

  // Sign correction and final HI/LO values written in FIX
  always_comb begin
    w_prod_mag = {w_core_hi, w_core_lo};
    w_prod     = r_neg_res ? -w_prod_mag : w_prod_mag;
    w_quot     = r_neg_res ? -w_core_lo : w_core_lo;
    w_rem      = r_neg_rem ? -w_core_hi : w_core_hi;
    {w_res_hi, w_res_lo} = w_prod;
    if (r_is_div) begin
      // Divide by zero: quotient all ones, remainder is the dividend itself
      w_res_hi = w_rem;
      w_res_lo = r_div_zero ? '1 : w_quot;
    end
`ifdef MDU_MADD_EN
    else if (r_madd) begin
      {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod;
    end else if (r_msub) begin
      {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod;
    end
`endif
  end

  // Control FSM with registered busy/done and the architectural HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef MDU_MADD_EN
      r_madd     <= 1'b0;
      r_msub     <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_load) begin
            r_state    <= StCalc;
            r_busy     <= 1'b1;
            r_is_div   <= w_is_div;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            r_div_zero <= (bus.opB == '0);
`ifdef MDU_MADD_EN
            r_madd     <= (bus.op == MDU_MADD);
            r_msub     <= (bus.op == MDU_MSUB);
`endif
          end else if (w_accept && bus.op == MDU_MTHI) begin
            r_hi <= bus.opA;
          end else if (w_accept && bus.op == MDU_MTLO) begin
            r_lo <= bus.opA;
          end
        end
        StCalc: begin
          if (bus.cancel) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (w_step_done) begin
            r_state <= StFix;
          end
        end
        StFix: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          if (!bus.cancel) begin
            r_hi   <= w_res_hi;
            r_lo   <= w_res_lo;
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Parametrised successor of the datapath ALU's single-cycle MULT/MULTU path.
- Adds DIV/DIVU, MTHI/MTLO and a start/busy/done handshake with cancel.
- Sits beside the ALU in EX. MFHI/MFLO read hi/lo directly, and the pipeline stalls on busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved (MADD/MSUB).
- opA  input  WIDTH  rs operand; dividend or multiplicand.
- opB  input  WIDTH  rt operand; divisor or multiplier.
- cancel  input  1  abort the in-flight operation (exception flush).
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse when HI/LO updated by a multi-cycle op.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0.
  - Reset mid-operation discards the operation.
- States and transitions:
  - IDLE: start=1 with MULT/MULTU/DIV/DIVU latches |opA|, |opB| (signed ops take magnitudes) and result signs, then goes to CALC with counter=0.
  - IDLE: start=1 with MTHI/MTLO writes hi (or lo) = opA at that edge. State stays IDLE; no busy, no done.
  - CALC: one radix-2 step per cycle. Multiply is shift-add; divide is restoring shift-subtract. After WIDTH steps, go to FIX.
  - FIX: apply sign correction, write hi/lo, pulse done=1 for one cycle, go to IDLE.
- Latency:
  - Accept edge E0. hi/lo/done update at edge E(WIDTH+1), i.e. 33 edges for WIDTH=32.
  - busy=1 from after E0 until after E(WIDTH+1).
- Back-to-back: a new start may be accepted in the cycle done is high, since busy is already 0.
- start while busy=1 is ignored and produces no state change. The bench flags it as a protocol error.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
  - DIV/DIVU: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Divide by zero (opB=0): lo = all ones, hi = opA. The counter still runs to full latency.
  - DIV of most-negative by -1: lo = most-negative, hi = 0, with no trap.
- cancel:
  - In CALC or FIX it forces IDLE next edge; hi/lo are unchanged and done is not pulsed.
  - cancel and start in the same IDLE cycle: cancel wins and the request is dropped.
- Reserved op codes (without the optional feature) are accepted as no-ops: no busy, hi/lo unchanged.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 110 = MADD: {hi,lo} += signed product.
  - op 111 = MSUB: {hi,lo} -= signed product.
  - Both use the same latency as MULT; accumulation is modulo 2^(2*WIDTH), applied in FIX.
  - cancel leaves {hi,lo} unmodified.
- Undefined: 110/111 are reserved no-ops, and no accumulator adder is synthesised.

Decomposition:
- Shared package, e.g. the mdu_pkg section of ISA.v: the op encoding constants (MDU_MULT..MDU_MSUB) and the state encoding (IDLE, CALC, FIX).
- One natural sub-module, mdu_iter_core: holds the WIDTH-step shift-add/shift-subtract datapath and counter, and asserts step_done.
- The top level owns the FSM, sign handling, the hi/lo registers and cancel.

Test Plan:
- MULT opA=FFFFFFFD (-3), opB=00000005 -> after 33 edges done=1, hi=FFFFFFFF, lo=FFFFFFF1.
- MULTU opA=FFFFFFFF, opB=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; busy high for exactly 33 cycles.
- DIV opA=FFFFFFF9 (-7), opB=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU 100/7 -> lo=0000000E, hi=00000002.
- DIVU opA=00000005, opB=0 -> lo=FFFFFFFF, hi=00000005. DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- MTHI 12345678, then MTLO 9ABCDEF0 on consecutive cycles -> hi and lo update one edge after each, no done. Then cancel at cycle 10 of a MULT -> busy drops next edge, hi/lo unchanged, no done.
- rst_n asserted asynchronously at cycle 5 of a DIV -> all outputs 0 immediately. After release, start is accepted and the new DIV completes correctly. A start at the done cycle is accepted back-to-back.
